// File: rtl/lcd_bus_reader.sv
// rtl/lcd_bus_reader.sv - HD44780 read-side bus engine (status / data-RAM reads, busy-poll)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   req_valid/ready   read request handshake (ready only in IDLE)
//   req_rs            0 = status read, 1 = data RAM read
//   req_poll          repeat status reads while BF=1 (ignored for data reads)
//   rsp_valid         one-cycle response pulse, no backpressure
//   rsp_data          byte sampled on the last EN-high cycle, held until next response
//   rsp_timeout       qualified by rsp_valid: poll gave up with BF still 1
//   lcd_rs/rw/en      LCD control lines; lcd_rw=1 means the bus is released to the LCD
//   lcd_dat_i         LCD data bus input
module lcd_bus_reader #(
  parameter int T_AS     = 4,
  parameter int T_PW     = 24,
  parameter int T_HOLD   = 2,
  parameter int T_GAP    = 30,
  parameter int POLL_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  input  logic [7:0] lcd_dat_i
);

  localparam int T_MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int T_MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX) + 1;
  localparam int PW      = $clog2(POLL_MAX + 1);

  // Counters are loaded with N-1 so a phase occupies exactly N cycles.
  localparam logic [CW-1:0] LD_AS   = CW'(T_AS - 1);
  localparam logic [CW-1:0] LD_PW   = CW'(T_PW - 1);
  localparam logic [CW-1:0] LD_HOLD = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(T_GAP - 1);
  localparam logic [PW-1:0] P_MAX   = PW'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_GAP, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          poll_q, poll_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          rw_q, rw_d;
  logic          en_q, en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      poll_cnt_q <= '0;
      poll_q     <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= 8'h00;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      poll_cnt_q <= poll_cnt_d;
      poll_q     <= poll_d;
      timeout_q  <= timeout_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      en_q       <= en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    poll_cnt_d = poll_cnt_q;
    poll_d     = poll_q;
    timeout_d  = timeout_q;
    data_d     = data_q;
    rs_d       = rs_q;
    rw_d       = rw_q;
    en_d       = en_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rs_d       = req_rs;
          rw_d       = 1'b1;
          poll_d     = req_poll & ~req_rs;
          poll_cnt_d = '0;
          timeout_d  = 1'b0;
          cnt_d      = LD_AS;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          en_d    = 1'b1;
          cnt_d   = LD_PW;
          state_d = S_EN_HI;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EN_HI: begin
        if (cnt_q == '0) begin
          data_d     = lcd_dat_i;
          poll_cnt_d = poll_cnt_q + PW'(1);
          en_d       = 1'b0;
          cnt_d      = LD_HOLD;
          state_d    = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          rs_d    = 1'b0;
          rw_d    = 1'b0;
          cnt_d   = LD_GAP;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          // Busy flag is bit 7 of the status byte; polls are always RS=0.
          if (poll_q && data_q[7] && (poll_cnt_q < P_MAX)) begin
            rs_d    = 1'b0;
            rw_d    = 1'b1;
            cnt_d   = LD_AS;
            state_d = S_SETUP;
          end else begin
            if (poll_q && data_q[7]) begin
              timeout_d = 1'b1;
            end
            state_d = S_RESP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_data    = data_q;
  assign rsp_timeout = timeout_q;
  assign lcd_rs      = rs_q;
  assign lcd_rw      = rw_q;
  assign lcd_en      = en_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb/tb_lcd_bus_reader.sv - directed self-checking bench for lcd_bus_reader
module tb_lcd_bus_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic       req_poll = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_dat_i = 8'h00;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_read
  int         en_pulses, en_first, en_last, rs_last, rw_first, rw_last;
  int         rsp_cnt, rsp_cyc, viol;
  logic [7:0] rsp_d;
  logic       rsp_to, ready_req, ready_rsp, ready_after;

  always #5 clk = ~clk;

  lcd_bus_reader #(.POLL_MAX(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs     (req_rs),
    .req_poll   (req_poll),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_dat_i  (lcd_dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: lcd_dat_i = val constant
  // mode 1: 0x90 for the first 3 EN pulses, then 0x10
  // mode 2: 0xAA except 0x55 on the last EN-high cycle (28); req_valid pulse at cycle 10
  // Cycle k is the interval between clock edge k-1 and edge k; edge 0 is the handshake.
  task automatic run_read(input logic rs, input logic poll, input int mode,
                          input logic [7:0] val, input int ncyc);
    logic en_prev, rs_prev, rw_prev;
    en_pulses = 0; en_first = -1; en_last = -1; rs_last = -1;
    rw_first = -1; rw_last = -1; rsp_cnt = 0; rsp_cyc = -1; viol = 0;
    rsp_d = 8'h00; rsp_to = 1'b0; ready_rsp = 1'bx; ready_after = 1'bx;
    @(negedge clk);
    req_rs = rs; req_poll = poll; req_valid = 1'b1;
    lcd_dat_i = (mode == 1) ? 8'h90 : (mode == 2) ? 8'hAA : val;
    ready_req = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    en_prev = 1'b0; rs_prev = lcd_rs; rw_prev = lcd_rw;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (lcd_en && !en_prev) en_pulses++;
      if (lcd_en) begin
        if (en_first < 0) en_first = k;
        en_last = k;
      end
      if ((lcd_en || en_prev) && k > 1 && (lcd_rs !== rs_prev || lcd_rw !== rw_prev)) viol++;
      if (lcd_rs) rs_last = k;
      if (lcd_rw) begin
        if (rw_first < 0) rw_first = k;
        rw_last = k;
      end
      if (rsp_cyc > 0 && k == rsp_cyc + 1) ready_after = req_ready;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = k;
        rsp_d = rsp_data;
        rsp_to = rsp_timeout;
        ready_rsp = req_ready;
      end
      if (mode == 1) lcd_dat_i = (en_pulses <= 3) ? 8'h90 : 8'h10;
      if (mode == 2) begin
        lcd_dat_i = (k == 28) ? 8'h55 : 8'hAA;
        if (k == 10) req_valid = 1'b1;
        if (k == 11) req_valid = 1'b0;
      end
      en_prev = lcd_en; rs_prev = lcd_rs; rw_prev = lcd_rw;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int stray;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_lcd_en", lcd_en, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Status read, 0x25
    run_read(1'b0, 1'b0, 0, 8'h25, 65);
    chk("st_ready_req", ready_req, 1);
    chk("st_en_pulses", en_pulses, 1);
    chk("st_en_first", en_first, 5);
    chk("st_en_last", en_last, 28);
    chk("st_rs_never", rs_last, 32'hFFFF_FFFF);
    chk("st_rw_first", rw_first, 1);
    chk("st_rw_last", rw_last, 30);
    chk("st_rsp_cyc", rsp_cyc, 61);
    chk("st_rsp_cnt", rsp_cnt, 1);
    chk("st_rsp_data", rsp_d, 8'h25);
    chk("st_rsp_to", rsp_to, 0);
    chk("st_ready_in_rsp", ready_rsp, 0);
    chk("st_ready_after", ready_after, 1);
    chk("st_stable", viol, 0);
    chk("st_data_held", rsp_data, 8'h25);

    // Data read, 0x46
    run_read(1'b1, 1'b0, 0, 8'h46, 65);
    chk("dr_rs_last", rs_last, 30);
    chk("dr_rw_last", rw_last, 30);
    chk("dr_rsp_cyc", rsp_cyc, 61);
    chk("dr_rsp_data", rsp_d, 8'h46);
    chk("dr_stable", viol, 0);

    // Data read with req_poll=1 and bit 7 set: still a single read
    run_read(1'b1, 1'b1, 0, 8'hC3, 130);
    chk("dp_en_pulses", en_pulses, 1);
    chk("dp_rsp_cyc", rsp_cyc, 61);
    chk("dp_rsp_data", rsp_d, 8'hC3);
    chk("dp_rsp_to", rsp_to, 0);

    // Poll: 3 busy reads then ready
    run_read(1'b0, 1'b1, 1, 8'h00, 245);
    chk("pl_en_pulses", en_pulses, 4);
    chk("pl_rsp_cyc", rsp_cyc, 241);
    chk("pl_rsp_cnt", rsp_cnt, 1);
    chk("pl_rsp_data", rsp_d, 8'h10);
    chk("pl_rsp_to", rsp_to, 0);
    chk("pl_rs_never", rs_last, 32'hFFFF_FFFF);
    chk("pl_stable", viol, 0);

    // Poll timeout with POLL_MAX=5
    run_read(1'b0, 1'b1, 0, 8'hFF, 310);
    chk("to_en_pulses", en_pulses, 5);
    chk("to_rsp_cyc", rsp_cyc, 301);
    chk("to_rsp_cnt", rsp_cnt, 1);
    chk("to_rsp_data", rsp_d, 8'hFF);
    chk("to_rsp_to", rsp_to, 1);

    // Last-cycle sampling and ignored mid-read request
    run_read(1'b0, 1'b0, 2, 8'h00, 130);
    chk("ls_rsp_data", rsp_d, 8'h55);
    chk("ls_rsp_cyc", rsp_cyc, 61);
    chk("ls_rsp_cnt", rsp_cnt, 1);
    chk("ls_en_pulses", en_pulses, 1);
    chk("ls_rsp_to", rsp_to, 0);

    // Asynchronous reset during EN_HI
    @(negedge clk);
    req_rs = 1'b1; req_poll = 1'b0; req_valid = 1'b1; lcd_dat_i = 8'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("ar_en_before", lcd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", lcd_en, 0);
    chk("ar_rw", lcd_rw, 0);
    chk("ar_rs", lcd_rs, 0);
    chk("ar_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (rsp_valid || lcd_en) stray++;
    end
    chk("ar_no_activity", stray, 0);
    chk("ar_ready", req_ready, 1);
    chk("ar_data_cleared", rsp_data, 8'h00);
    run_read(1'b0, 1'b0, 0, 8'h37, 65);
    chk("ar_rsp_cyc", rsp_cyc, 61);
    chk("ar_rsp_data", rsp_d, 8'h37);
    chk("ar_en_first", en_first, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
